// File: rtl/tv_capture.sv
// Test-vector recorder: captures {cap_in, cap_out} pairs into block RAM during
// CAPTURE, then streams them out in order over a valid/ready port during DUMP.
module tv_capture #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          cap_valid,
  input  logic [WIDTH_IN-1:0]           cap_in,
  input  logic [WIDTH_OUT-1:0]          cap_out,
  input  logic                          dump_req,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [WIDTH_IN+WIDTH_OUT-1:0] rd_data,
  output logic                          rd_last,
  output logic [ADDR_W:0]               count,
  output logic                          full,
  output logic                          overflow,
  output logic                          busy
);

  localparam int DW = WIDTH_IN + WIDTH_OUT;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DUMP} state_e;

  state_e          state_q;
  logic [ADDR_W:0] count_q;
  logic            overflow_q;
  logic [ADDR_W:0] rd_addr_q;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   ram_rd_q;

  logic            pend_q;
  logic            pend_last_q;
  logic            rd_valid_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_last_q;
  logic            skid_valid_q;
  logic [DW-1:0]   skid_data_q;
  logic            skid_last_q;

  logic            full_d;
  logic            wr_en_d;
  logic            dump_go_d;
  logic            dump_issue_d;
  logic            rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic            issue_last_d;
  logic            pop_d;
  logic [1:0]      buf_occ_d;

  always_comb begin
    full_d    = (count_q == DEPTH_C);
    pop_d     = rd_valid_q && rd_ready;
    wr_en_d   = (state_q == CAPTURE) && cap_valid && !start && !full_d;
    dump_go_d = (state_q == IDLE) && dump_req && !start && (count_q != '0);
    // Words held after this edge; a new read is issued only if it will fit
    // into the output register plus skid register when it lands.
    buf_occ_d = {1'b0, rd_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q} - {1'b0, pop_d};
    dump_issue_d = (state_q == DUMP) && (rd_addr_q < count_q) && (buf_occ_d < 2'd2);
    rd_en_d   = dump_go_d || dump_issue_d;
    rd_addr_d = dump_go_d ? '0 : rd_addr_q[ADDR_W-1:0];
    issue_last_d = dump_go_d ? (count_q == ONE_C) : (rd_addr_q == count_q - ONE_C);
  end

  // Buffer RAM: no reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem[count_q[ADDR_W-1:0]] <= {cap_in, cap_out};
    end
    if (rd_en_d) begin
      ram_rd_q <= mem[rd_addr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      pend_q      <= rd_en_d;
      pend_last_q <= issue_last_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CAPTURE;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end else if (dump_go_d) begin
            state_q   <= DUMP;
            rd_addr_q <= ONE_C;
          end
        end
        CAPTURE: begin
          if (start) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
          end else begin
            if (wr_en_d) begin
              count_q <= count_q + ONE_C;
            end else if (cap_valid && full_d) begin
              overflow_q <= 1'b1;
            end
            if (stop) begin
              state_q <= IDLE;
            end
          end
        end
        DUMP: begin
          if (dump_issue_d) begin
            rd_addr_q <= rd_addr_q + ONE_C;
          end
          if (pop_d && rd_last_q) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Output register refills from the skid first, then from the RAM, so
      // order is preserved and a stall never drops an in-flight read.
      if (pop_d) begin
        if (skid_valid_q) begin
          rd_data_q    <= skid_data_q;
          rd_last_q    <= skid_last_q;
          skid_valid_q <= pend_q;
          skid_data_q  <= ram_rd_q;
          skid_last_q  <= pend_last_q;
        end else if (pend_q) begin
          rd_data_q <= ram_rd_q;
          rd_last_q <= pend_last_q;
        end else begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
        end
      end else if (pend_q) begin
        if (!rd_valid_q) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= ram_rd_q;
          rd_last_q  <= pend_last_q;
        end else begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= ram_rd_q;
          skid_last_q  <= pend_last_q;
        end
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign count    = count_q;
  assign full     = full_d;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_tv_capture.sv
// Self-checking bench for tv_capture: a per-cycle vector table for reset and a
// basic capture/dump, then hand-written sequences for stalls, fill and abort.
module tb_tv_capture;

  logic        clk = 1'b0;
  logic        reset, start, stop, cap_valid, dump_req, rd_ready;
  logic [7:0]  cap_in, cap_out;
  logic        rd_valid, rd_last, full, overflow, busy;
  logic [15:0] rd_data;
  logic [10:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tv_capture #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cap_valid(cap_valid), .cap_in(cap_in), .cap_out(cap_out),
    .dump_req(dump_req), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .count(count),
    .full(full), .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic rn, st, sp, cv;
    logic [7:0] ci, co;
    logic dq, rdy;
    logic e_valid;
    logic [15:0] e_data;
    logic chk_data;
    logic e_last;
    logic [10:0] e_count;
    logic e_busy, e_full, e_ovf;
  } vec_t;

  function automatic vec_t v(input logic rn, st, sp, cv, input logic [7:0] ci, co,
                             input logic dq, rdy, ev, input logic [15:0] ed,
                             input logic cd, el, input logic [10:0] ec,
                             input logic eb, ef, eo);
    vec_t r;
    r.rn = rn; r.st = st; r.sp = sp; r.cv = cv; r.ci = ci; r.co = co;
    r.dq = dq; r.rdy = rdy; r.e_valid = ev; r.e_data = ed; r.chk_data = cd;
    r.e_last = el; r.e_count = ec; r.e_busy = eb; r.e_full = ef; r.e_ovf = eo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 0; stop = 0; cap_valid = 0; dump_req = 0; cap_in = 0; cap_out = 0;
  endtask

  task automatic capture(input logic [7:0] ci, input logic [7:0] co);
    cap_valid = 1; cap_in = ci; cap_out = co;
    tick;
    cap_valid = 0;
  endtask

  vec_t vt[14];
  logic [15:0] got_data[$];
  logic        got_last[$];
  logic        pre_valid, pre_last;
  logic [15:0] pre_data;
  logic        rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] exp3[3] = '{16'h1122, 16'h3344, 16'h5566};

  initial begin
    reset = 0; rd_ready = 0;
    idle_inputs();

    vt[0]  = v(0,1,0,1,8'hAA,8'h55,0,0, 0,16'h0000,1,0,11'd0,0,0,0);
    vt[1]  = v(0,1,0,1,8'hAA,8'h55,0,0, 0,16'h0000,1,0,11'd0,0,0,0);
    vt[2]  = v(1,1,0,0,8'h00,8'h00,0,0, 0,16'h0000,0,0,11'd0,1,0,0);
    vt[3]  = v(1,0,0,1,8'h01,8'hFF,0,0, 0,16'h0000,0,0,11'd1,1,0,0);
    vt[4]  = v(1,0,0,1,8'h02,8'hFE,0,0, 0,16'h0000,0,0,11'd2,1,0,0);
    vt[5]  = v(1,0,0,1,8'h80,8'h80,0,0, 0,16'h0000,0,0,11'd3,1,0,0);
    vt[6]  = v(1,0,0,1,8'h00,8'h00,0,0, 0,16'h0000,0,0,11'd4,1,0,0);
    vt[7]  = v(1,0,1,0,8'h00,8'h00,0,0, 0,16'h0000,0,0,11'd4,0,0,0);
    vt[8]  = v(1,0,0,0,8'h00,8'h00,1,1, 0,16'h0000,0,0,11'd4,1,0,0);
    vt[9]  = v(1,0,0,0,8'h00,8'h00,0,1, 1,16'h01FF,1,0,11'd4,1,0,0);
    vt[10] = v(1,0,0,0,8'h00,8'h00,0,1, 1,16'h02FE,1,0,11'd4,1,0,0);
    vt[11] = v(1,0,0,0,8'h00,8'h00,0,1, 1,16'h8080,1,0,11'd4,1,0,0);
    vt[12] = v(1,0,0,0,8'h00,8'h00,0,1, 1,16'h0000,1,1,11'd4,1,0,0);
    vt[13] = v(1,0,0,0,8'h00,8'h00,0,1, 0,16'h0000,0,0,11'd4,0,0,0);

    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rn; start = vt[i].st; stop = vt[i].sp; cap_valid = vt[i].cv;
      cap_in = vt[i].ci; cap_out = vt[i].co; dump_req = vt[i].dq; rd_ready = vt[i].rdy;
      tick;
      $display("[TB] vec %0d: valid=%0b data=0x%04h last=%0b count=%0d busy=%0b",
               i, rd_valid, rd_data, rd_last, count, busy);
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_rd_last", i),  32'(rd_last),  32'(vt[i].e_last));
      chk($sformatf("vec%0d_count", i),    32'(count),    32'(vt[i].e_count));
      chk($sformatf("vec%0d_busy", i),     32'(busy),     32'(vt[i].e_busy));
      chk($sformatf("vec%0d_full", i),     32'(full),     32'(vt[i].e_full));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
      if (vt[i].chk_data) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vt[i].e_data));
    end
    idle_inputs(); rd_ready = 0;

    // Three-entry dump under back-pressure.
    start = 1; tick; start = 0;
    capture(8'h11, 8'h22); capture(8'h33, 8'h44); capture(8'h55, 8'h66);
    stop = 1; tick; stop = 0;
    chk("stall_count", 32'(count), 32'd3);
    dump_req = 1; tick; dump_req = 0;
    begin
      int w = 0;
      while (!rd_valid && w < 10) begin tick; w++; end
      if (!rd_valid) timeout("stall_first_valid");
    end
    for (int s = 0; s < 6; s++) begin
      rd_ready = rdy_pat[s];
      pre_valid = rd_valid; pre_data = rd_data; pre_last = rd_last;
      tick;
      if (pre_valid && rdy_pat[s]) begin
        got_data.push_back(pre_data); got_last.push_back(pre_last);
        $display("[TB] stall step %0d: transfer 0x%04h last=%0b", s, pre_data, pre_last);
      end else if (pre_valid) begin
        $display("[TB] stall step %0d: hold 0x%04h", s, rd_data);
        chk($sformatf("stall%0d_data_stable", s), 32'(rd_data), 32'(pre_data));
        chk($sformatf("stall%0d_last_stable", s), 32'(rd_last), 32'(pre_last));
      end
    end
    rd_ready = 0;
    chk("stall_xfer_count", 32'(got_data.size()), 32'd3);
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      chk($sformatf("stall_word%0d", k), 32'(got_data[k]), 32'(exp3[k]));
      chk($sformatf("stall_last%0d", k), 32'(got_last[k]), (k == 2) ? 32'd1 : 32'd0);
    end
    chk("stall_end_valid", 32'(rd_valid), 32'd0);
    chk("stall_end_busy", 32'(busy), 32'd0);

    // Fill to DEPTH and overflow by two.
    start = 1; tick; start = 0;
    for (int i = 0; i < 1026; i++) begin
      cap_valid = 1; cap_in = i[7:0]; cap_out = ~cap_in;
      tick;
      if (i == 1023) begin
        chk("fill_full_at_1024", 32'(full), 32'd1);
        chk("fill_no_ovf_at_1024", 32'(overflow), 32'd0);
      end
    end
    cap_valid = 0;
    $display("[TB] fill: count=%0d full=%0b overflow=%0b", count, full, overflow);
    chk("fill_count", 32'(count), 32'd1024);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_overflow", 32'(overflow), 32'd1);
    stop = 1; tick; stop = 0;
    rd_ready = 1; dump_req = 1; tick; dump_req = 0;
    begin
      int n = 0, errs = 0, lasts = 0, first_c = -1, last_c = -1, cyc = 0;
      logic [15:0] w1023 = 16'h0;
      logic        l1023 = 1'b0;
      while (busy && cyc < 1100) begin
        pre_valid = rd_valid; pre_data = rd_data; pre_last = rd_last;
        tick;
        if (pre_valid) begin
          logic [7:0] b;
          b = n[7:0];
          if (pre_data !== {b, ~b}) errs++;
          if (pre_last) lasts++;
          if (n == 1023) begin w1023 = pre_data; l1023 = pre_last; end
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          n++;
        end
        cyc++;
      end
      if (busy) timeout("fill_dump_end");
      $display("[TB] fill dump: %0d words, last word 0x%04h last=%0b", n, w1023, l1023);
      chk("fill_dump_words", 32'(n), 32'd1024);
      chk("fill_dump_data_errors", 32'(errs), 32'd0);
      chk("fill_entry1023", 32'(w1023), 32'hFF00);
      chk("fill_entry1023_last", 32'(l1023), 32'd1);
      chk("fill_last_flags", 32'(lasts), 32'd1);
      chk("fill_no_bubbles", 32'(last_c - first_c + 1), 32'd1024);
      chk("fill_count_kept", 32'(count), 32'd1024);
    end
    rd_ready = 0;

    // Empty-buffer dump request, then start+dump_req together.
    reset = 0; tick; reset = 1;
    dump_req = 1; tick; dump_req = 0;
    $display("[TB] empty dump_req: busy=%0b valid=%0b", busy, rd_valid);
    chk("empty_dump_busy", 32'(busy), 32'd0);
    tick;
    chk("empty_dump_valid", 32'(rd_valid), 32'd0);
    start = 1; dump_req = 1; tick; start = 0; dump_req = 0;
    $display("[TB] start+dump_req: busy=%0b count=%0d", busy, count);
    chk("start_wins_busy", 32'(busy), 32'd1);
    chk("start_wins_count", 32'(count), 32'd0);
    capture(8'h05, 8'h06);
    chk("start_wins_capturing", 32'(count), 32'd1);
    chk("start_wins_no_valid", 32'(rd_valid), 32'd0);
    stop = 1; tick; stop = 0;

    // Reset in the middle of a dump.
    start = 1; tick; start = 0;
    capture(8'hA1, 8'h1A); capture(8'hB2, 8'h2B); capture(8'hC3, 8'h3C); capture(8'hD4, 8'h4D);
    stop = 1; tick; stop = 0;
    rd_ready = 1; dump_req = 1; tick; dump_req = 0;
    begin
      int x = 0, c = 0;
      while (x < 2 && c < 20) begin
        pre_valid = rd_valid;
        tick;
        if (pre_valid) x++;
        c++;
      end
      if (x < 2) timeout("abort_two_transfers");
    end
    reset = 0; tick; reset = 1;
    $display("[TB] abort: valid=%0b count=%0d busy=%0b", rd_valid, count, busy);
    chk("abort_valid", 32'(rd_valid), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_last", 32'(rd_last), 32'd0);
    chk("abort_data", 32'(rd_data), 32'd0);
    dump_req = 1; tick; dump_req = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_redump_busy%0d", k), 32'(busy), 32'd0);
      chk($sformatf("abort_redump_valid%0d", k), 32'(rd_valid), 32'd0);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
